// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode and control-unit state encodings, SYS func3 values.
// Used by both the combinational decoder and the control-unit sequencer.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP_RG3 = 7'b0110011,
        SYS    = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4
    } cu_state_t;

    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    // True for the three SYS func3 codes that read-modify-write a CSR.
    function automatic logic is_csr_op(input logic [2:0] f3);
        return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
    endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bundle: instruction fields and interrupt inputs in, timed enables out.
// The master side is the sequencer; the slave side is the datapath.
interface otter_cu_fsm_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       intr;
    logic       mie;

    logic       PC_WE;
    logic       RF_WE;
    logic       memWE2;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       reset;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;

    modport master (
        input  opcode, func3, intr, mie,
        output PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2,
               reset, csr_WE, int_taken, mret_exec
    );

    modport slave (
        output opcode, func3, intr, mie,
        input  PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2,
               reset, csr_WE, int_taken, mret_exec
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle sequencer: steps each instruction through INIT/FETCH/EXEC/WB/INTR
// and produces unregistered write/read enables, datapath reset and trap strobes.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter bit INTR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           RST,
    otter_cu_fsm_if.master cu
);

    cu_state_t state_reg;
    cu_state_t state_next;
    logic      intr_pend;

    // Sampled only in the cycle that completes an instruction; intr is never latched.
    assign intr_pend = INTR_EN && cu.intr && cu.mie;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cu.PC_WE     = 1'b0;
        cu.RF_WE     = 1'b0;
        cu.memWE2    = 1'b0;
        cu.memRDEN1  = 1'b0;
        cu.memRDEN2  = 1'b0;
        cu.reset     = 1'b0;
        cu.csr_WE    = 1'b0;
        cu.int_taken = 1'b0;
        cu.mret_exec = 1'b0;

        case (state_reg)
            INIT: begin
                cu.reset   = 1'b1;
                state_next = FETCH;
            end

            FETCH: begin
                cu.memRDEN1 = 1'b1;
                state_next  = EXEC;
            end

            EXEC: begin
                if (cu.opcode == LOAD) begin
                    // Load data arrives a cycle later, so the PC holds until WB.
                    cu.memRDEN2 = 1'b1;
                    state_next  = WB;
                end else begin
                    cu.PC_WE = 1'b1;
                    case (cu.opcode)
                        STORE: begin
                            cu.memWE2 = 1'b1;
                        end
                        LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
                            cu.RF_WE = 1'b1;
                        end
                        SYS: begin
                            if (cu.func3 == F3_PRIV) begin
                                cu.mret_exec = 1'b1;
                            end else if (is_csr_op(cu.func3)) begin
                                cu.csr_WE = 1'b1;
                                cu.RF_WE  = 1'b1;
                            end
                        end
                        default: begin
                            // BRANCH and illegal opcodes only advance the PC.
                        end
                    endcase
                    state_next = intr_pend ? INTR : FETCH;
                end
            end

            WB: begin
                cu.RF_WE   = 1'b1;
                cu.PC_WE   = 1'b1;
                state_next = intr_pend ? INTR : FETCH;
            end

            INTR: begin
                // MIE is cleared by the CSR file on int_taken, so no re-sample here.
                cu.int_taken = 1'b1;
                cu.PC_WE     = 1'b1;
                state_next   = FETCH;
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: directed vectors with literal expectations plus a per-cycle
// instruction-level model compared against an interrupt-enabled and an interrupt-disabled build.
module tb_otter_cu_fsm;

    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_SYS  = 7'b1110011;
    localparam logic [6:0] OPC_BAD  = 7'b1111111;

    // Output vector order: PC_WE RF_WE memWE2 memRDEN1 memRDEN2 reset csr_WE int_taken mret_exec
    localparam logic [8:0] V_INIT  = 9'b000001000;
    localparam logic [8:0] V_FETCH = 9'b000100000;
    localparam logic [8:0] V_ALU   = 9'b110000000;
    localparam logic [8:0] V_LDEX  = 9'b000010000;
    localparam logic [8:0] V_LDWB  = 9'b110000000;
    localparam logic [8:0] V_STORE = 9'b101000000;
    localparam logic [8:0] V_PCONL = 9'b100000000;
    localparam logic [8:0] V_INTR  = 9'b100000010;
    localparam logic [8:0] V_CSR   = 9'b110000100;
    localparam logic [8:0] V_MRET  = 9'b100000001;

    // Model phases of an instruction's life, independent of the DUT's encoding.
    localparam int PH_RESET = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_LOADWB = 3;
    localparam int PH_TRAP  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op_r = OPC_ADDI;
    logic [2:0] f3_r = 3'b000;
    logic       intr_r = 1'b0;
    logic       mie_r = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    otter_cu_fsm_if bus_a ();
    otter_cu_fsm_if bus_b ();

    assign bus_a.opcode = op_r;
    assign bus_a.func3  = f3_r;
    assign bus_a.intr   = intr_r;
    assign bus_a.mie    = mie_r;
    assign bus_b.opcode = op_r;
    assign bus_b.func3  = f3_r;
    assign bus_b.intr   = intr_r;
    assign bus_b.mie    = mie_r;

    otter_cu_fsm #(.INTR_EN(1'b1)) dut (.clk(clk), .RST(rst), .cu(bus_a));
    otter_cu_fsm #(.INTR_EN(1'b0)) dut_ni (.clk(clk), .RST(rst), .cu(bus_b));

    always #5 clk = ~clk;

    logic [8:0] outs_a;
    logic [8:0] outs_b;
    assign outs_a = {bus_a.PC_WE, bus_a.RF_WE, bus_a.memWE2, bus_a.memRDEN1, bus_a.memRDEN2,
                     bus_a.reset, bus_a.csr_WE, bus_a.int_taken, bus_a.mret_exec};
    assign outs_b = {bus_b.PC_WE, bus_b.RF_WE, bus_b.memWE2, bus_b.memRDEN1, bus_b.memRDEN2,
                     bus_b.reset, bus_b.csr_WE, bus_b.int_taken, bus_b.mret_exec};

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // What an instruction must do in a given phase, from the instruction's class.
    function automatic logic [8:0] model_out(input int ph, input logic [6:0] op, input logic [2:0] f3);
        logic [8:0] v;
        logic is_sys;
        logic is_csr;
        logic writes_rd;
        v = '0;
        is_sys = (op == OPC_SYS);
        is_csr = is_sys && (f3 >= 3'd1) && (f3 <= 3'd3);
        writes_rd = (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                7'b0010011, 7'b0110011}) || is_csr;
        case (ph)
            PH_RESET: v[3] = 1'b1;
            PH_FETCH: v[5] = 1'b1;
            PH_EXEC: begin
                if (op == OPC_LW) begin
                    v[4] = 1'b1;
                end else begin
                    v[8] = 1'b1;
                    v[7] = writes_rd;
                    v[6] = (op == OPC_SW);
                    v[2] = is_csr;
                    v[0] = is_sys && (f3 == 3'b000);
                end
            end
            PH_LOADWB: v = 9'b110000000;
            PH_TRAP:   v = 9'b100000010;
            default:   v = 'x;
        endcase
        return v;
    endfunction

    function automatic int model_next(input int ph, input logic [6:0] op, input logic r,
                                      input logic irq_ok);
        logic done;
        if (r) return PH_RESET;
        done = (ph == PH_LOADWB) || (ph == PH_EXEC && op != OPC_LW);
        if (done) return irq_ok ? PH_TRAP : PH_FETCH;
        case (ph)
            PH_RESET: return PH_FETCH;
            PH_FETCH: return PH_EXEC;
            PH_EXEC:  return PH_LOADWB;
            default:  return PH_FETCH;
        endcase
    endfunction

    // rst is high from time 0, so both builds are in reset after the first edge.
    int ph_a = PH_RESET;
    int ph_b = PH_RESET;

    always @(negedge clk) begin
        logic [8:0] ma;
        logic [8:0] mb;
        ma = model_out(ph_a, op_r, f3_r);
        mb = model_out(ph_b, op_r, f3_r);
        chk("model_intr_en", outs_a, ma);
        chk("model_intr_dis", outs_b, mb);
        chk("mem_exclusive", {8'b0, ($countones(outs_a[6:4]) <= 1)}, 9'd1);
        ph_a = model_next(ph_a, op_r, rst, intr_r && mie_r);
        ph_b = model_next(ph_b, op_r, rst, 1'b0);
    end

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic i, input logic m,
                       input logic r, input logic [8:0] exp, input string name);
        @(posedge clk);
        #1;
        op_r = op;
        f3_r = f3;
        intr_r = i;
        mie_r = m;
        rst = r;
        #1;
        chk(name, outs_a, exp);
    endtask

    initial begin
        run(OPC_ADDI, 3'd0, 1'b0, 1'b0, 1'b1, V_INIT,  "reset_cycle1");
        run(OPC_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, V_INIT,  "reset_cycle2");
        run(OPC_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "startup_fetch");
        run(OPC_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, V_ALU,   "addi_exec");
        run(OPC_LW,   3'd2, 1'b0, 1'b0, 1'b0, V_FETCH, "lw_fetch");
        run(OPC_LW,   3'd2, 1'b0, 1'b0, 1'b0, V_LDEX,  "lw_exec");
        run(OPC_LW,   3'd2, 1'b0, 1'b0, 1'b0, V_LDWB,  "lw_wb");
        run(OPC_SW,   3'd2, 1'b0, 1'b0, 1'b0, V_FETCH, "sw_fetch");
        run(OPC_SW,   3'd2, 1'b0, 1'b0, 1'b0, V_STORE, "sw_exec");
        run(OPC_BEQ,  3'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "beq_fetch");
        run(OPC_BEQ,  3'd0, 1'b0, 1'b0, 1'b0, V_PCONL, "beq_exec");
        run(OPC_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, V_FETCH, "irq_addi_fetch");
        run(OPC_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, V_ALU,   "irq_addi_exec");
        run(OPC_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, V_INTR,  "irq_entry");
        chk("irq_disabled_build", outs_b, V_FETCH);
        run(OPC_ADDI, 3'd0, 1'b1, 1'b0, 1'b0, V_FETCH, "after_irq_fetch");
        run(OPC_ADDI, 3'd0, 1'b1, 1'b0, 1'b0, V_ALU,   "mie0_exec");
        run(OPC_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, V_FETCH, "mie0_no_irq");
        run(OPC_ADDI, 3'd0, 1'b0, 1'b1, 1'b0, V_ALU,   "pulse_exec");
        run(OPC_LW,   3'd2, 1'b1, 1'b1, 1'b0, V_FETCH, "pulse_dropped");
        run(OPC_LW,   3'd2, 1'b1, 1'b1, 1'b0, V_LDEX,  "lw_irq_exec");
        run(OPC_LW,   3'd2, 1'b1, 1'b1, 1'b0, V_LDWB,  "lw_irq_wb");
        run(OPC_SYS,  3'd1, 1'b0, 1'b0, 1'b0, V_INTR,  "lw_then_irq");
        run(OPC_SYS,  3'd1, 1'b0, 1'b0, 1'b0, V_FETCH, "csrrw_fetch");
        run(OPC_SYS,  3'd1, 1'b0, 1'b0, 1'b0, V_CSR,   "csrrw_exec");
        run(OPC_SYS,  3'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "mret_fetch");
        run(OPC_SYS,  3'd0, 1'b0, 1'b0, 1'b0, V_MRET,  "mret_exec");
        run(OPC_BAD,  3'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "illegal_fetch");
        run(OPC_BAD,  3'd0, 1'b0, 1'b0, 1'b0, V_PCONL, "illegal_exec");
        run(OPC_LW,   3'd2, 1'b0, 1'b0, 1'b0, V_FETCH, "lw_rst_fetch");
        run(OPC_LW,   3'd2, 1'b0, 1'b0, 1'b1, V_LDEX,  "lw_rst_exec");
        run(OPC_LW,   3'd2, 1'b0, 1'b0, 1'b0, V_INIT,  "rst_mid_lw");
        chk("rst_mid_lw_dis", outs_b, V_INIT);
        run(OPC_SYS,  3'd0, 1'b1, 1'b1, 1'b0, V_FETCH, "post_rst_fetch");
        run(OPC_SYS,  3'd0, 1'b1, 1'b1, 1'b0, V_MRET,  "mret_with_irq");
        run(OPC_SYS,  3'd5, 1'b0, 1'b0, 1'b0, V_INTR,  "mret_then_irq");
        chk("mret_irq_dis", outs_b, V_FETCH);
        run(OPC_SYS,  3'd5, 1'b0, 1'b0, 1'b0, V_FETCH, "sysnop_fetch");
        run(OPC_SYS,  3'd5, 1'b0, 1'b0, 1'b0, V_PCONL, "sysnop_exec");
        run(OPC_LUI,  3'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "lui_fetch");
        run(OPC_LUI,  3'd0, 1'b0, 1'b0, 1'b0, V_ALU,   "lui_exec");
        run(OPC_LUI,  3'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "lui_done");
        @(posedge clk);
        #6;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
